slm_line_streamer: RTL and testbench



---
 rtl/slm_line_streamer.sv | 184 ++++++++++++++++++
 tb/tb_slm_line_streamer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/slm_line_streamer.sv
// rtl/slm_line_streamer.sv - reads whole lines from the line FIFO and streams them to the SLM
// with start-of-frame/line and end-of-line markers, line counting and stall detection.
module slm_line_streamer #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned WORDS_PER_LINE  = 64,
  parameter int unsigned LINES_PER_FRAME = 1024,
  parameter int unsigned LINE_CNT_W      = 11,
  parameter int unsigned GAP_CYCLES      = 4,
  parameter int unsigned TIMEOUT         = 4096
) (
  input  logic                  fpga_clk,
  input  logic                  reset_all,
  input  logic                  next_frame_rdy,
  input  logic                  line_of_data_available,
  output logic                  fifo_rd_en,
  input  logic [DATA_W-1:0]     fifo_rd_data,
  output logic [DATA_W-1:0]     slm_data,
  output logic                  slm_valid,
  output logic                  slm_sof,
  output logic                  slm_sol,
  output logic                  slm_eol,
  output logic [LINE_CNT_W-1:0] line_count,
  output logic                  frame_done,
  output logic                  underrun_err
);

  localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LINE,
    S_READ_LINE,
    S_LINE_GAP,
    S_FRAME_END
  } state_t;

  state_t                state_q, state_d;
  logic [6:0]            word_cnt_q, word_cnt_d;
  logic [LINE_CNT_W-1:0] lines_issued_q, lines_issued_d;
  logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  fifo_rd_en_q, fifo_rd_en_d;
  logic [DATA_W-1:0]     slm_data_q, slm_data_d;
  logic                  slm_valid_q, slm_valid_d;
  logic                  slm_sof_q, slm_sof_d;
  logic                  slm_sol_q, slm_sol_d;
  logic                  slm_eol_q, slm_eol_d;
  logic [LINE_CNT_W-1:0] line_count_q, line_count_d;
  logic                  frame_done_q, frame_done_d;
  logic                  underrun_q, underrun_d;

  logic last_word;
  logic last_line;

  assign last_word = (word_cnt_q == 7'(WORDS_PER_LINE - 1));
  assign last_line = (lines_issued_q == LINE_CNT_W'(LINES_PER_FRAME - 1));

  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    lines_issued_d = lines_issued_q;
    wait_cnt_d     = '0;
    gap_cnt_d      = '0;
    fifo_rd_en_d   = 1'b0;
    slm_data_d     = slm_data_q;
    slm_valid_d    = 1'b0;
    slm_sof_d      = 1'b0;
    slm_sol_d      = 1'b0;
    slm_eol_d      = 1'b0;
    line_count_d   = line_count_q;
    frame_done_d   = 1'b0;
    underrun_d     = underrun_q;

    // The FIFO word for the current strobe is sampled at the same edge that ends the read cycle.
    if (fifo_rd_en_q) begin
      slm_valid_d = 1'b1;
      slm_data_d  = fifo_rd_data;
      slm_sol_d   = (word_cnt_q == '0);
      slm_eol_d   = last_word;
      slm_sof_d   = (word_cnt_q == '0) && (lines_issued_q == '0);
    end

    if (slm_eol_q && (line_count_q != LINE_CNT_W'(LINES_PER_FRAME))) begin
      line_count_d = line_count_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (next_frame_rdy) begin
          state_d        = S_WAIT_LINE;
          line_count_d   = '0;
          lines_issued_d = '0;
        end
      end
      S_WAIT_LINE: begin
        if (line_of_data_available) begin
          state_d      = S_READ_LINE;
          fifo_rd_en_d = 1'b1;
          word_cnt_d   = '0;
        end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d      = S_IDLE;
          underrun_d   = 1'b1;
          line_count_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      S_READ_LINE: begin
        if (last_word) begin
          word_cnt_d     = '0;
          lines_issued_d = lines_issued_q + 1'b1;
          if (last_line) begin
            state_d      = S_FRAME_END;
            frame_done_d = 1'b1;
          end else begin
            state_d = S_LINE_GAP;
          end
        end else begin
          word_cnt_d   = word_cnt_q + 1'b1;
          fifo_rd_en_d = 1'b1;
        end
      end
      S_LINE_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = S_WAIT_LINE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_FRAME_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge fpga_clk) begin
    if (reset_all) begin
      state_q        <= S_IDLE;
      word_cnt_q     <= '0;
      lines_issued_q <= '0;
      wait_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      fifo_rd_en_q   <= 1'b0;
      slm_data_q     <= '0;
      slm_valid_q    <= 1'b0;
      slm_sof_q      <= 1'b0;
      slm_sol_q      <= 1'b0;
      slm_eol_q      <= 1'b0;
      line_count_q   <= '0;
      frame_done_q   <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      word_cnt_q     <= word_cnt_d;
      lines_issued_q <= lines_issued_d;
      wait_cnt_q     <= wait_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      fifo_rd_en_q   <= fifo_rd_en_d;
      slm_data_q     <= slm_data_d;
      slm_valid_q    <= slm_valid_d;
      slm_sof_q      <= slm_sof_d;
      slm_sol_q      <= slm_sol_d;
      slm_eol_q      <= slm_eol_d;
      line_count_q   <= line_count_d;
      frame_done_q   <= frame_done_d;
      underrun_q     <= underrun_d;
    end
  end

  assign fifo_rd_en   = fifo_rd_en_q;
  assign slm_data     = slm_data_q;
  assign slm_valid    = slm_valid_q;
  assign slm_sof      = slm_sof_q;
  assign slm_sol      = slm_sol_q;
  assign slm_eol      = slm_eol_q;
  assign line_count   = line_count_q;
  assign frame_done   = frame_done_q;
  assign underrun_err = underrun_q;

endmodule

// File: tb/tb_slm_line_streamer.sv
// tb/tb_slm_line_streamer.sv - directed bench for slm_line_streamer with a FIFO model
// and an expected-word scoreboard.
module tb_slm_line_streamer;

  localparam int DATA_W = 32;
  localparam int WPL    = 4;
  localparam int LPF    = 3;
  localparam int LCW    = 11;
  localparam int GAP    = 2;
  localparam int TMO    = 16;

  logic              fpga_clk = 1'b0;
  logic              reset_all;
  logic              next_frame_rdy;
  logic              line_of_data_available;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [DATA_W-1:0] slm_data;
  logic              slm_valid, slm_sof, slm_sol, slm_eol;
  logic [LCW-1:0]    line_count;
  logic              frame_done, underrun_err;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic sof;
    logic sol;
    logic eol;
    logic fd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] fifo_ptr = '0;
  int          rd_in_frame = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          n_words = 0;

  always #5 fpga_clk = ~fpga_clk;

  assign fifo_rd_data = fifo_ptr;

  slm_line_streamer #(
    .DATA_W(DATA_W), .WORDS_PER_LINE(WPL), .LINES_PER_FRAME(LPF),
    .LINE_CNT_W(LCW), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
  ) dut (
    .fpga_clk(fpga_clk), .reset_all(reset_all), .next_frame_rdy(next_frame_rdy),
    .line_of_data_available(line_of_data_available), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .slm_data(slm_data), .slm_valid(slm_valid),
    .slm_sof(slm_sof), .slm_sol(slm_sol), .slm_eol(slm_eol), .line_count(line_count),
    .frame_done(frame_done), .underrun_err(underrun_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: word on fifo_rd_data is consumed at the edge that ends a strobed cycle.
  always @(posedge fpga_clk) begin
    if (fifo_rd_en) fifo_ptr <= fifo_ptr + 1;
    if (reset_all) begin
      sb.delete();
      rd_in_frame = 0;
    end else if (fifo_rd_en) begin
      sb.push_back('{data: fifo_ptr,
                     sof: (rd_in_frame == 0),
                     sol: (rd_in_frame % WPL == 0),
                     eol: (rd_in_frame % WPL == WPL - 1),
                     fd:  (rd_in_frame == WPL * LPF - 1)});
      rd_in_frame = (rd_in_frame + 1) % (WPL * LPF);
    end
  end

  always @(negedge fpga_clk) begin
    exp_t e;
    if (slm_valid) begin
      n_words++;
      chk("word_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("slm_data", 64'(slm_data), 64'(e.data));
        chk("markers", {60'd0, slm_sof, slm_sol, slm_eol, frame_done},
            {60'd0, e.sof, e.sol, e.eol, e.fd});
      end
    end else begin
      chk("idle_markers", {60'd0, slm_sof, slm_sol, slm_eol, frame_done}, 64'd0);
    end
  end

  task automatic wait_fd(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge fpga_clk);
      if (frame_done) seen = 1'b1;
    end
  endtask

  initial begin
    logic [19:0] pat20;
    logic [7:0]  pat8;
    bit          seen;
    int          cnt;

    reset_all = 1'b1;
    next_frame_rdy = 1'b0;
    line_of_data_available = 1'b0;
    repeat (3) @(negedge fpga_clk);
    chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    chk("rst_valid", 64'(slm_valid), 64'd0);
    chk("rst_data", 64'(slm_data), 64'd0);
    chk("rst_line_count", 64'(line_count), 64'd0);
    chk("rst_underrun", 64'(underrun_err), 64'd0);

    // Single frame with availability held high.
    reset_all = 1'b0;
    line_of_data_available = 1'b1;
    next_frame_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge fpga_clk);
      next_frame_rdy = 1'b0;
      pat20[19-i] = fifo_rd_en;
      if (i == 19) chk("t1_frame_done_on_last", 64'({frame_done, slm_eol}), 64'b11);
    end
    chk("t1_rd_en_pattern", 64'(pat20), 64'(20'b0_1111_000_1111_000_1111_0));
    @(negedge fpga_clk);
    chk("t1_line_count", 64'(line_count), 64'(LPF));
    chk("t1_frame_done_pulse", 64'(frame_done), 64'd0);
    chk("t1_words", 64'(n_words), 64'd12);

    // Availability pulsed for one cycle only.
    line_of_data_available = 1'b0;
    next_frame_rdy = 1'b1;
    @(negedge fpga_clk);
    next_frame_rdy = 1'b0;
    line_of_data_available = 1'b1;
    @(negedge fpga_clk);
    line_of_data_available = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pat8[7-i] = fifo_rd_en;
      @(negedge fpga_clk);
    end
    chk("t2_burst", 64'(pat8), 64'(8'b1111_0000));
    line_of_data_available = 1'b1;
    wait_fd(60, seen);
    chk("t2_frame_done_seen", 64'(seen), 64'd1);
    @(negedge fpga_clk);
    chk("t2_line_count", 64'(line_count), 64'(LPF));

    // No availability after frame start: underrun.
    line_of_data_available = 1'b0;
    next_frame_rdy = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge fpga_clk);
      next_frame_rdy = 1'b0;
      if (fifo_rd_en) cnt++;
      if (i == 16) chk("t3_underrun_before", 64'(underrun_err), 64'd0);
      if (i == 17) chk("t3_underrun_after", 64'(underrun_err), 64'd1);
    end
    chk("t3_no_reads", 64'(cnt), 64'd0);
    chk("t3_line_count", 64'(line_count), 64'd0);
    line_of_data_available = 1'b1;
    next_frame_rdy = 1'b1;
    @(negedge fpga_clk);
    next_frame_rdy = 1'b0;
    wait_fd(60, seen);
    chk("t3_frame_after_underrun", 64'(seen), 64'd1);
    chk("t3_underrun_sticky", 64'(underrun_err), 64'd1);
    @(negedge fpga_clk);
    chk("t3_line_count_full", 64'(line_count), 64'(LPF));

    // Reset during the third read of line 1.
    next_frame_rdy = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge fpga_clk);
      next_frame_rdy = 1'b0;
    end
    chk("t4_third_read", 64'(fifo_rd_en), 64'd1);
    chk("t4_line_count_pre", 64'(line_count), 64'd1);
    reset_all = 1'b1;
    @(negedge fpga_clk);
    chk("t4_rd_en_dropped", 64'(fifo_rd_en), 64'd0);
    chk("t4_valid_dropped", 64'(slm_valid), 64'd0);
    chk("t4_line_count_clr", 64'(line_count), 64'd0);
    reset_all = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge fpga_clk);
      if (fifo_rd_en) cnt++;
    end
    chk("t4_no_reads", 64'(cnt), 64'd0);
    chk("t4_underrun_cleared", 64'(underrun_err), 64'd0);

    // Back-to-back frames with next_frame_rdy held high.
    next_frame_rdy = 1'b1;
    wait_fd(60, seen);
    chk("t5_first_frame", 64'(seen), 64'd1);
    @(negedge fpga_clk);
    chk("t5_line_count_idle", 64'(line_count), 64'(LPF));
    chk("t5_idle_no_read", 64'(fifo_rd_en), 64'd0);
    @(negedge fpga_clk);
    chk("t5_line_count_restart", 64'(line_count), 64'd0);
    chk("t5_wait_no_read", 64'(fifo_rd_en), 64'd0);
    @(negedge fpga_clk);
    chk("t5_read_resumes", 64'(fifo_rd_en), 64'd1);
    wait_fd(60, seen);
    next_frame_rdy = 1'b0;
    chk("t5_second_frame", 64'(seen), 64'd1);
    repeat (4) @(negedge fpga_clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("total_words", 64'(n_words), 64'd66);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
